// File: rtl/argon_writeback_queue.sv
// rtl/argon_writeback_queue.sv - round-robin arbitrated write-back FIFO feeding the Argon register file write port (optional ARGON_WB_COALESCE_EN)
module argon_writeback_queue #(
    parameter int INDEXWIDTH = 3,
    parameter int DATAWIDTH  = 16,
    parameter int DEPTH      = 4,
    parameter int PTRWIDTH   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_aluValid,
    output logic                  o_aluReady,
    input  logic [INDEXWIDTH-1:0] i_aluSelect,
    input  logic [DATAWIDTH-1:0]  i_aluData,
    input  logic                  i_memValid,
    output logic                  o_memReady,
    input  logic [INDEXWIDTH-1:0] i_memSelect,
    input  logic [DATAWIDTH-1:0]  i_memData,
    input  logic                  i_drainEn,
    output logic                  o_writeEn,
    output logic [INDEXWIDTH-1:0] o_selectW,
    output logic [DATAWIDTH-1:0]  o_wdata,
    input  logic [INDEXWIDTH-1:0] i_querySelect,
    output logic                  o_queryPending,
    output logic [PTRWIDTH:0]     o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [PTRWIDTH:0] FULL_COUNT = (PTRWIDTH + 1)'(DEPTH);

    logic [INDEXWIDTH-1:0] sel_mem  [DEPTH];
    logic [DATAWIDTH-1:0]  data_mem [DEPTH];
    logic [PTRWIDTH-1:0]   head;
    logic [PTRWIDTH-1:0]   tail;
    logic [PTRWIDTH-1:0]   tail_last;
    logic [PTRWIDTH:0]     count;
    logic                  last_grant_alu;

    logic                  pop;
    logic                  tail_popped;
    logic                  coal_alu;
    logic                  coal_mem;
    logic                  alu_wins;
    logic                  mem_wins;
    logic                  grant_alu;
    logic                  grant_mem;
    logic                  granted;
    logic [INDEXWIDTH-1:0] g_sel;
    logic [DATAWIDTH-1:0]  g_data;
    logic                  g_coal;
    logic                  push;

    assign o_count   = count;
    assign o_full    = (count == FULL_COUNT);
    assign o_empty   = (count == '0);
    assign tail_last = tail - PTRWIDTH'(1);

    assign pop         = !o_empty && i_drainEn;
    assign o_writeEn   = pop;
    assign o_selectW   = o_empty ? '0 : sel_mem[head];
    assign o_wdata     = o_empty ? '0 : data_mem[head];
    // The newest entry cannot absorb a write if it is leaving the queue this edge.
    assign tail_popped = pop && (count == (PTRWIDTH + 1)'(1));

`ifdef ARGON_WB_COALESCE_EN
    assign coal_alu = !o_empty && !tail_popped && (i_aluSelect != '0)
                      && (i_aluSelect == sel_mem[tail_last]);
    assign coal_mem = !o_empty && !tail_popped && (i_memSelect != '0)
                      && (i_memSelect == sel_mem[tail_last]);
`else
    assign coal_alu = 1'b0;
    assign coal_mem = 1'b0;
`endif

    // Tie goes to the source that did not win the previous transfer.
    assign alu_wins  = i_aluValid && (!i_memValid || !last_grant_alu);
    assign mem_wins  = i_memValid && !alu_wins;
    assign grant_alu = !i_reset && alu_wins && (!o_full || coal_alu);
    assign grant_mem = !i_reset && mem_wins && (!o_full || coal_mem);
    assign granted   = grant_alu || grant_mem;

    assign o_aluReady = grant_alu;
    assign o_memReady = grant_mem;

    assign g_sel  = grant_alu ? i_aluSelect : i_memSelect;
    assign g_data = grant_alu ? i_aluData   : i_memData;
    assign g_coal = grant_alu ? coal_alu    : coal_mem;
    // Register 0 is hardwired, so its writes are accepted and dropped.
    assign push   = granted && (g_sel != '0) && !g_coal;

    // Hazard check over occupied slots only; r0 never reports pending.
    always_comb begin
        o_queryPending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTRWIDTH'(i) - head} < count)
                && (sel_mem[i] == i_querySelect) && (i_querySelect != '0)) begin
                o_queryPending = 1'b1;
            end
        end
    end

    // Pointer, occupancy and arbitration history.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            last_grant_alu <= 1'b1;
        end else begin
            if (pop) begin
                head <= head + PTRWIDTH'(1);
            end
            if (push) begin
                tail <= tail + PTRWIDTH'(1);
            end
            if (granted) begin
                last_grant_alu <= grant_alu;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTRWIDTH + 1)'(1);
                2'b01:   count <= count - (PTRWIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: new writes land at the tail, coalesced writes refresh the newest entry.
    always_ff @(posedge i_clk) begin
        if (push) begin
            sel_mem[tail]  <= g_sel;
            data_mem[tail] <= g_data;
        end else if (granted && g_coal) begin
            data_mem[tail_last] <= g_data;
        end
    end

endmodule

// File: tb/tb_argon_writeback_queue.sv
// tb/tb_argon_writeback_queue.sv - directed plus randomized checks of argon_writeback_queue against a queue model
module tb_argon_writeback_queue;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        av, mv, drain;
    logic [2:0]  asel, msel, qs;
    logic [15:0] adata, mdata;
    logic        alu_ready, mem_ready, we, qpend, full, empty;
    logic [2:0]  selw;
    logic [15:0] wdata;
    logic [2:0]  count;

    ent_t q[$];
    bit   last_alu;
    bit   x_alu, x_mem;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    argon_writeback_queue dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_aluValid     (av),
        .o_aluReady     (alu_ready),
        .i_aluSelect    (asel),
        .i_aluData      (adata),
        .i_memValid     (mv),
        .o_memReady     (mem_ready),
        .i_memSelect    (msel),
        .i_memData      (mdata),
        .i_drainEn      (drain),
        .o_writeEn      (we),
        .o_selectW      (selw),
        .o_wdata        (wdata),
        .i_querySelect  (qs),
        .o_queryPending (qpend),
        .o_count        (count),
        .o_full         (full),
        .o_empty        (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit coal_ok(input logic [2:0] s, input bit popping);
`ifdef ARGON_WB_COALESCE_EN
        return (q.size() > 0) && (s != 0) && (s == q[q.size()-1].sel)
               && !(popping && q.size() == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit pending(input logic [2:0] s);
        if (s == 0) return 1'b0;
        foreach (q[i]) if (q[i].sel == s) return 1'b1;
        return 1'b0;
    endfunction

    // Check current outputs against the model, clock once, advance the model.
    task automatic step();
        bit   pop, aw, mw, ga, gm, cz;
        ent_t e;
        #1;
        pop = (q.size() > 0) && drain;
        aw  = av && (!mv || !last_alu);
        mw  = mv && !aw;
        ga  = !rst && aw && (q.size() < 4 || coal_ok(asel, pop));
        gm  = !rst && mw && (q.size() < 4 || coal_ok(msel, pop));
        chk("alu_ready", alu_ready, ga);
        chk("mem_ready", mem_ready, gm);
        if (!rst) begin
            chk("write_en", we, pop);
            chk("select_w", selw, q.size() > 0 ? q[0].sel : 3'd0);
            chk("wdata", wdata, q.size() > 0 ? q[0].data : 16'd0);
            chk("count", count, q.size());
            chk("full", full, q.size() == 4);
            chk("empty", empty, q.size() == 0);
            chk("query_pending", qpend, pending(qs));
        end
        cz = 1'b0;
        e.sel = 3'd0;
        e.data = 16'd0;
        if (ga) begin e.sel = asel; e.data = adata; cz = coal_ok(asel, pop); end
        if (gm) begin e.sel = msel; e.data = mdata; cz = coal_ok(msel, pop); end
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_alu = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (ga || gm) begin
                last_alu = ga;
                if (e.sel != 0) begin
                    if (cz) q[q.size()-1].data = e.data;
                    else    q.push_back(e);
                end
            end
        end
        x_alu = ga;
        x_mem = gm;
        #1;
    endtask

    initial begin
        rst = 1'b1; av = 0; mv = 0; drain = 0; asel = 0; msel = 0; qs = 0;
        adata = 0; mdata = 0; last_alu = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0; drain = 1'b1; qs = 3'd3;
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_we", we, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_qpend", qpend, 0);

        // Single ALU write, one cycle of queue latency.
        av = 1; asel = 3'd3; adata = 16'h1234;
        step();
        av = 0;
        #1;
        chk("lat_we", we, 1);
        chk("lat_sel", selw, 3);
        chk("lat_data", wdata, 16'h1234);
        step();
        chk("lat_empty", empty, 1);

        // Both sources contend, drain stalled: alternating grants, then full.
        drain = 0; av = 1; mv = 1;
        asel = 3'd1; adata = 16'hA001; msel = 3'd2; mdata = 16'hB001;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_mem_ready", mem_ready, (k % 2) == 0);
            chk("rr_alu_ready", alu_ready, (k % 2) == 1);
            step();
            if (x_alu) begin asel = asel + 3'd1; adata = adata + 16'd1; end
            if (x_mem) begin msel = msel + 3'd1; mdata = mdata + 16'd1; end
        end
        #1;
        chk("rr_full", full, 1);
        chk("rr_full_alu_ready", alu_ready, 0);
        chk("rr_full_mem_ready", mem_ready, 0);
        step();

        // Drain the full queue in order.
        av = 0; mv = 0; drain = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_count", count, 4 - k);
            step();
        end
        chk("drain_done", count, 0);

        // Write to r0 is accepted and discarded.
        av = 1; asel = 3'd0; adata = 16'hFFFF;
        #1;
        chk("r0_ready", alu_ready, 1);
        step();
        av = 0;
        #1;
        chk("r0_count", count, 0);
        chk("r0_we", we, 0);

        // Hazard query.
        drain = 0; av = 1; asel = 3'd5; adata = 16'h0055;
        step();
        av = 0; qs = 3'd5;
        #1;
        chk("query_hit", qpend, 1);
        qs = 3'd0;
        #1;
        chk("query_r0", qpend, 0);
        qs = 3'd5; drain = 1;
        step();
        chk("query_after_pop", qpend, 0);

`ifdef ARGON_WB_COALESCE_EN
        drain = 0; av = 1; asel = 3'd2; adata = 16'h0001;
        step();
        adata = 16'h0002;
        step();
        av = 0;
        #1;
        chk("coal_count", count, 1);
        chk("coal_data", wdata, 16'h0002);
        av = 1; asel = 3'd4; step();
        asel = 3'd6; step();
        av = 0;
        #1;
        chk("coal_three", count, 3);
        rst = 1; step(); rst = 0;
        #1;
        chk("coal_reset", count, 0);
`endif

        // Randomized traffic with valid held until transfer.
        av = 0; mv = 0;
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            drain = $urandom_range(0, 1);
            qs    = $urandom_range(0, 7);
            if (!av || x_alu) begin
                av = $urandom_range(0, 1); asel = $urandom_range(0, 7); adata = $urandom;
            end
            if (!mv || x_mem) begin
                mv = $urandom_range(0, 1); msel = $urandom_range(0, 7); mdata = $urandom;
            end
            x_alu = 0; x_mem = 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/argon_writeback_queue.md
# argon_writeback_queue

Write-side companion to the Argon register file: accepts register write requests from the ALU and memory paths through valid/ready handshakes, arbitrates round-robin, and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file's single write port (write enable, write select, write data). It also exposes a hazard query so decode can stall on registers with writes still queued.

## Interface
- INDEXWIDTH, 3, register index width; matches the register file.
- DATAWIDTH, 16, write data width.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- PTRWIDTH, 2, log2(DEPTH).

- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_aluValid  in  1  ALU write request valid
- o_aluReady  out  1  ALU request accepted this cycle
- i_aluSelect  in  INDEXWIDTH  ALU destination register
- i_aluData  in  DATAWIDTH  ALU write data
- i_memValid  in  1  memory write request valid
- o_memReady  out  1  memory request accepted this cycle
- i_memSelect  in  INDEXWIDTH  memory destination register
- i_memData  in  DATAWIDTH  memory write data
- i_drainEn  in  1  register file write port available this cycle
- o_writeEn  out  1  to register file write enable
- o_selectW  out  INDEXWIDTH  to register file write select
- o_wdata  out  DATAWIDTH  to register file write data
- i_querySelect  in  INDEXWIDTH  register index to check
- o_queryPending  out  1  a queued entry targets i_querySelect
- o_count  out  PTRWIDTH+1  entries held
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0

## Operation
- Handshake: transfer on a source when valid && ready at the rising edge. Valid may not be withdrawn before its transfer; ready may depend combinationally on both valids.
- Arbitration: at most one grant per cycle, only when !o_full. Single valid source → granted. Both valid → the source not granted last time wins; a 1-bit lastGrant updates only on a transfer. After reset, memory wins the first tie.
- Index 0: request with select 0 is granted and completes the handshake but is discarded (no enqueue, lastGrant still updates).
- Enqueue: granted nonzero request written at tail, tail pointer wraps modulo DEPTH.
- Drain: o_writeEn = !o_empty && i_drainEn; o_selectW/o_wdata = head entry, zero when empty. Head pops on each edge where o_writeEn is 1.
- Simultaneous enqueue and pop: allowed when not full; count unchanged. When full, no grant even if a pop occurs that cycle.
- o_queryPending: combinational OR over occupied entries of (select == i_querySelect); forced 0 for i_querySelect == 0.
- Reset mid-operation: all queued entries are dropped, pointers and count clear, in-flight requests are not accepted that edge.

## Timing
- Reset values: o_writeEn 0, o_selectW 0, o_wdata 0, o_count 0, o_empty 1, o_full 0, o_queryPending 0, both readys reflect empty queue (ready when valid after reset deasserts).
- Latency: request accepted at edge N into empty queue → o_writeEn high during cycle N+1 (if i_drainEn) → register file written at edge N+1 … N+2 boundary, i.e. one cycle of queue latency.
- Throughput: one accept and one drain per cycle sustained.
- o_queryPending reflects queue state after the last edge; it does not see the same-cycle request.

## Configuration
- ARGON_WB_COALESCE_EN defined: a granted request whose select equals the tail (newest) entry's select overwrites that entry's data instead of enqueuing, provided that entry is not popped this same edge; count unchanged; grant also allowed when full if coalescing.
- Not defined: every nonzero granted request occupies its own entry; full always blocks grants.

## Test plan
- Reset, then ALU writes r3=0x1234 with i_drainEn=1 → next cycle o_writeEn=1, o_selectW=3, o_wdata=0x1234; o_empty back to 1 one cycle later.
- Both sources valid for 4 cycles, i_drainEn=0 → grant order mem, ALU, mem, ALU; o_full=1, both readys 0 on cycle 5.
- i_drainEn=0, fill to DEPTH, then drain → 4 writes in enqueue order, pointers wrap, o_count steps 4→0.
- ALU write to r0 with data 0xFFFF → o_aluReady=1, o_count stays 0, o_writeEn stays 0.
- Queue holds r5, i_querySelect=5 → o_queryPending=1; after pop, 0; i_querySelect=0 → always 0.
- With ARGON_WB_COALESCE_EN, drain off: r2=0x1 then r2=0x2 → o_count=1, drained value 0x2; reset asserted with 3 entries → o_count=0 next cycle.
